alu_exec_unit: RTL and testbench

//  Sequential execution wrapper around addsub_8bit for the FPGA ALU datapath.
//  - Upstream: accepts one add/sub request per valid/ready handshake.
//  - Operands come from the inputs or from an internal 8-bit accumulator.
//  - Captures Y/Cout, derives Z/N/V flags and updates the accumulator.
//  - Downstream: presents result and flags to the writeback/display stage via valid/ready.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_exec_unit_if.sv | 33 +++
 rtl/addsub_8bit.sv | 15 +
 rtl/alu_exec_unit.sv | 107 ++++++++++
 tb/tb_alu_exec_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU execution unit: width, FSM states,
// status flag bundle and the raw-result flag derivation.
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } alu_flags_t;

    // Flags of the raw adder result; callers re-derive z/n when the result is saturated.
    function automatic alu_flags_t calc_flags(
        input logic [ALU_W-1:0] a,
        input logic [ALU_W-1:0] b,
        input logic [ALU_W-1:0] y,
        input logic             cout,
        input logic             sel
    );
        alu_flags_t f;
        f.c = cout;
        f.z = (y == '0);
        f.n = y[ALU_W-1];
        if (sel) begin
            f.v = (a[ALU_W-1] != b[ALU_W-1]) && (y[ALU_W-1] != a[ALU_W-1]);
        end else begin
            f.v = (a[ALU_W-1] == b[ALU_W-1]) && (y[ALU_W-1] != a[ALU_W-1]);
        end
        return f;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/result bus of the ALU execution unit. Handshake: a transfer happens on a
// rising clk edge where valid and ready are both 1; valid-side payload is held until then.
interface alu_exec_unit_if;
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [ALU_W-1:0] in_a;
    logic [ALU_W-1:0] in_b;
    logic             in_sel;
    logic             in_acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [ALU_W-1:0] out_y;
    logic             out_c;
    logic             out_z;
    logic             out_n;
    logic             out_v;
    logic [ALU_W-1:0] acc_q;
    alu_state_t       dbg_state;

    modport master (
        output in_valid, in_a, in_b, in_sel, in_acc, acc_clr, out_ready,
        input  in_ready, out_valid, out_y, out_c, out_z, out_n, out_v, acc_q, dbg_state
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, in_acc, acc_clr, out_ready,
        output in_ready, out_valid, out_y, out_c, out_z, out_n, out_v, acc_q, dbg_state
    );

endinterface

// File: rtl/addsub_8bit.sv
// Combinational 8-bit adder/subtractor: sel=0 gives A+B, sel=1 gives A+~B+1.
module addsub_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       sel,
    output logic [7:0] Y,
    output logic       Cout
);

    logic [7:0] b_eff;

    assign b_eff     = sel ? ~B : B;
    assign {Cout, Y} = {1'b0, A} + {1'b0, b_eff} + {8'd0, sel};

endmodule

// File: rtl/alu_exec_unit.sv
// Sequential add/sub execution unit: accepts a request in IDLE, evaluates it in EXEC,
// holds result and flags in DONE until consumed, and keeps a running accumulator.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter logic [ALU_W-1:0] ACC_INIT = 8'h00,
    parameter bit               SAT_EN   = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    alu_exec_unit_if.slave bus
);

    alu_state_t       state_q;
    logic [ALU_W-1:0] op_a_q;
    logic [ALU_W-1:0] op_b_q;
    logic             op_sel_q;
    logic [ALU_W-1:0] acc_q;
    logic [ALU_W-1:0] y_q;
    alu_flags_t       flags_q;

    logic [ALU_W-1:0] op_a_d;
    logic [ALU_W-1:0] raw_y;
    logic             raw_c;
    logic [ALU_W-1:0] y_d;
    alu_flags_t       flags_d;

    addsub_8bit u_addsub (
        .A    (op_a_q),
        .B    (op_b_q),
        .sel  (op_sel_q),
        .Y    (raw_y),
        .Cout (raw_c)
    );

    // A clear in the accept cycle bypasses the stale accumulator.
    always_comb begin
        op_a_d = bus.in_a;
        if (bus.in_acc) begin
            op_a_d = bus.acc_clr ? ACC_INIT : acc_q;
        end
    end

    always_comb begin
        y_d = raw_y;
        if (SAT_EN) begin
            if (!op_sel_q && raw_c) begin
                y_d = '1;
            end else if (op_sel_q && !raw_c) begin
                y_d = '0;
            end
        end
        flags_d   = calc_flags(op_a_q, op_b_q, raw_y, raw_c, op_sel_q);
        flags_d.z = (y_d == '0);
        flags_d.n = y_d[ALU_W-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_sel_q <= 1'b0;
            acc_q    <= ACC_INIT;
            y_q      <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a_q   <= op_a_d;
                        op_b_q   <= bus.in_b;
                        op_sel_q <= bus.in_sel;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    y_q     <= y_d;
                    flags_q <= flags_d;
                    acc_q   <= y_d;
                    state_q <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Placed last so a clear wins over the EXEC accumulator write.
            if (bus.acc_clr) begin
                acc_q <= ACC_INIT;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_y     = y_q;
    assign bus.out_c     = flags_q.c;
    assign bus.out_z     = flags_q.z;
    assign bus.out_n     = flags_q.n;
    assign bus.out_v     = flags_q.v;
    assign bus.acc_q     = acc_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: a wrapping unit (ACC_INIT=0) and a saturating unit
// (ACC_INIT=8'h10) driven in lockstep and checked against an arithmetic reference model.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam logic [7:0] INIT0 = 8'h00;
    localparam logic [7:0] INIT1 = 8'h10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic       in_sel = 1'b0;
    logic       in_acc = 1'b0;
    logic       acc_clr = 1'b0;
    logic       out_ready = 1'b0;

    int          checks = 0;
    int          failures = 0;
    logic [11:0] exp_q0[$];
    logic [11:0] exp_q1[$];
    logic [7:0]  acc_m0 = INIT0;
    logic [7:0]  acc_m1 = INIT1;

    always #5 clk = ~clk;

    alu_exec_unit_if bus0 ();
    alu_exec_unit_if bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_a      = in_a;
    assign bus0.in_b      = in_b;
    assign bus0.in_sel    = in_sel;
    assign bus0.in_acc    = in_acc;
    assign bus0.acc_clr   = acc_clr;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_a      = in_a;
    assign bus1.in_b      = in_b;
    assign bus1.in_sel    = in_sel;
    assign bus1.in_acc    = in_acc;
    assign bus1.acc_clr   = acc_clr;
    assign bus1.out_ready = out_ready;

    alu_exec_unit #(.ACC_INIT(INIT0), .SAT_EN(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    alu_exec_unit #(.ACC_INIT(INIT1), .SAT_EN(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Result packed as {y[7:0], c, z, n, v}, computed from integer arithmetic.
    function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic sel, input logic sat);
        int ua, ub, sa, sb, r, sr;
        logic c, v;
        logic [7:0] y;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        if (!sel) begin
            r  = ua + ub;
            c  = (r > 255);
            sr = sa + sb;
        end else begin
            r  = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end
        v = (sr > 127) || (sr < -128);
        y = r[7:0];
        if (sat && !sel && c) y = 8'hFF;
        if (sat && sel && !c) y = 8'h00;
        return {y, c, (y == 8'h00), y[7], v};
    endfunction

    function automatic logic [11:0] obs0();
        return {bus0.out_y, bus0.out_c, bus0.out_z, bus0.out_n, bus0.out_v};
    endfunction

    function automatic logic [11:0] obs1();
        return {bus1.out_y, bus1.out_c, bus1.out_z, bus1.out_n, bus1.out_v};
    endfunction

    task automatic check_idle_reset();
        check("rst_valid0", bus0.out_valid, 0);
        check("rst_valid1", bus1.out_valid, 0);
        check("rst_out0", obs0(), 0);
        check("rst_out1", obs1(), 0);
        check("rst_acc0", bus0.acc_q, INIT0);
        check("rst_acc1", bus1.acc_q, INIT1);
        check("rst_ready0", bus0.in_ready, 1);
        check("rst_state0", 32'(bus0.dbg_state), 32'(IDLE));
    endtask

    // clr_phase: 0 none, 1 clear in the accept cycle, 2 clear in the EXEC cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sel,
                          input logic use_acc, input int clr_phase, input int hold);
        logic [7:0]  opa0, opa1;
        logic [11:0] e0, e1, s0, s1;
        @(negedge clk);
        check("idle_ready0", bus0.in_ready, 1);
        check("idle_ready1", bus1.in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sel   = sel;
        in_acc   = use_acc;
        acc_clr  = (clr_phase == 1);
        opa0 = use_acc ? ((clr_phase == 1) ? INIT0 : acc_m0) : a;
        opa1 = use_acc ? ((clr_phase == 1) ? INIT1 : acc_m1) : a;
        e0 = model(opa0, b, sel, 1'b0);
        e1 = model(opa1, b, sel, 1'b1);
        exp_q0.push_back(e0);
        exp_q1.push_back(e1);
        acc_m0 = (clr_phase == 2) ? INIT0 : e0[11:4];
        acc_m1 = (clr_phase == 2) ? INIT1 : e1[11:4];
        @(posedge clk);
        #1;
        in_valid = 1'($urandom_range(0, 1));
        in_a     = 8'($urandom);
        in_acc   = 1'($urandom_range(0, 1));
        acc_clr  = (clr_phase == 2);
        @(negedge clk);
        check("exec_valid0", bus0.out_valid, 0);
        check("exec_ready0", bus0.in_ready, 0);
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        @(negedge clk);
        check("done_valid0", bus0.out_valid, 1);
        check("done_valid1", bus1.out_valid, 1);
        check("done_ready0", bus0.in_ready, 0);
        s0 = (exp_q0.size() > 0) ? exp_q0.pop_front() : 12'hFFF;
        s1 = (exp_q1.size() > 0) ? exp_q1.pop_front() : 12'hFFF;
        check("result0", obs0(), s0);
        check("result1", obs1(), s1);
        check("acc0", bus0.acc_q, acc_m0);
        check("acc1", bus1.acc_q, acc_m1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            @(negedge clk);
            check("hold_valid0", bus0.out_valid, 1);
            check("hold_ready0", bus0.in_ready, 0);
            check("hold_out0", obs0(), s0);
            check("hold_out1", obs1(), s1);
            check("hold_acc0", bus0.acc_q, acc_m0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("back_idle0", bus0.in_ready, 1);
        check("back_nvalid0", bus0.out_valid, 0);
        check("back_nvalid1", bus1.out_valid, 0);
    endtask

    task automatic reset_mid_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sel   = 1'b0;
        in_acc   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        acc_m0 = INIT0;
        acc_m1 = INIT1;
        @(negedge clk);
        check_idle_reset();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_reset();

        run_op(8'd5, 8'd3, 1'b0, 1'b0, 0, 0);
        run_op(8'd5, 8'd3, 1'b1, 1'b0, 0, 0);
        run_op(8'd0, 8'd1, 1'b1, 1'b0, 0, 0);
        run_op(8'd255, 8'd1, 1'b0, 1'b0, 0, 0);
        run_op(8'd128, 8'd1, 1'b1, 1'b0, 0, 0);

        run_op(8'd77, 8'd5, 1'b0, 1'b1, 1, 0);
        run_op(8'd77, 8'd5, 1'b0, 1'b1, 0, 0);
        run_op(8'd77, 8'd5, 1'b0, 1'b1, 0, 0);
        check("acc_after_three", bus0.acc_q, 8'd15);
        run_op(8'd127, 8'd1, 1'b0, 1'b0, 0, 0);

        run_op(8'd200, 8'd100, 1'b0, 1'b0, 0, 5);
        run_op(8'd9, 8'd4, 1'b0, 1'b0, 2, 0);
        run_op(8'd0, 8'd3, 1'b0, 1'b1, 0, 0);
        reset_mid_op(8'd42, 8'd17);

        for (int k = 0; k < 40; k++) begin
            int ph;
            ph = int'($urandom_range(0, 7));
            run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), (ph < 2) ? ph + 1 : 0,
                   int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
